// File: rtl/aes256_encrypt_core.sv
// ============================================================================
// Module      : aes256_encrypt_core (with package aes256_pkg)
// Description : Iterative AES-256 encryption core. One cipher round per clock,
//               reading the 15 round keys live from the key expansion block.
//               Plaintext in and ciphertext out use valid/ready handshakes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   round_keys_i        15 x 128 round keys, element k = round key k
//   round_keys_valid_i  round keys stable and usable
//   plaintext_i         128-bit block, byte 0 in [127:120], column-major
//   plaintext_valid_i   plaintext offered
//   plaintext_ready_o   core can accept a block (IDLE and keys valid)
//   ciphertext_o        encrypted block, same byte order as plaintext_i
//   ciphertext_valid_o  ciphertext held valid until accepted
//   ciphertext_ready_i  downstream accepts ciphertext
//   key_abort_o         one-cycle pulse when an operation is dropped
//   block_count_o       (AES_BLOCK_COUNT_EN only) completed-block counter
// Optional feature macro: AES_BLOCK_COUNT_EN
// ============================================================================
`default_nettype none

package aes256_pkg;

    typedef logic [14:0][127:0] round_keys_t;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

endpackage

module aes256_encrypt_core
    import aes256_pkg::*;
#(
    parameter int NUM_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  round_keys_t  round_keys_i,
    input  logic         round_keys_valid_i,
    input  logic [127:0] plaintext_i,
    input  logic         plaintext_valid_i,
    output logic         plaintext_ready_o,
    output logic [127:0] ciphertext_o,
    output logic         ciphertext_valid_o,
    input  logic         ciphertext_ready_i,
    output logic         key_abort_o
`ifdef AES_BLOCK_COUNT_EN
    ,
    output logic [31:0]  block_count_o
`endif
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------
    generate
        if (NUM_ROUNDS != 14) begin : g_bad_num_rounds
            $error("aes256_encrypt_core: NUM_ROUNDS must be 14 for AES-256");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        ROUND_S = 2'd1,
        OUT_S   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Round transformation helpers (byte i of a block is bits [127-8i -: 8],
    // state[r][c] = byte r + 4c)
    // ------------------------------------------------------------------
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns: out[r][c] = in[r][(c + r) mod 4].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c      -: 8];
            a1 = s[127 - 32 * c - 8  -: 8];
            a2 = s[127 - 32 * c - 16 -: 8];
            a3 = s[127 - 32 * c - 24 -: 8];
            o[127 - 32 * c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32 * c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32 * c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32 * c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t       fsm_q,       fsm_d;
    logic [3:0]   round_q,     round_d;
    logic [127:0] aes_state_q, aes_state_d;
    logic [127:0] ct_q,        ct_d;
    logic         ct_valid_q,  ct_valid_d;
    logic         abort_q,     abort_d;

    logic [127:0] w_round_key;
    logic [127:0] w_shifted;
    logic [127:0] w_mixed;
    logic         w_ready;

    // round_q stays within 0..14 so the index is always in range.
    assign w_round_key = round_keys_i[round_q];
    assign w_shifted   = shift_rows(sub_bytes(aes_state_q));
    assign w_mixed     = mix_columns(w_shifted);

    // Held low while reset is asserted so every output reads zero in reset.
    assign w_ready = (fsm_q == IDLE_S) && round_keys_valid_i && !reset;

    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        aes_state_d = aes_state_q;
        ct_d        = ct_q;
        ct_valid_d  = ct_valid_q;
        abort_d     = 1'b0;

        case (fsm_q)
            IDLE_S: begin
                if (plaintext_valid_i && w_ready) begin
                    aes_state_d = plaintext_i ^ round_keys_i[0];
                    round_d     = 4'd1;
                    fsm_d       = ROUND_S;
                end
            end

            ROUND_S: begin
                if (!round_keys_valid_i) begin
                    // Keys are read live, so a block in flight cannot finish.
                    aes_state_d = '0;
                    round_d     = 4'd0;
                    abort_d     = 1'b1;
                    fsm_d       = IDLE_S;
                end else if (round_q == LAST_ROUND) begin
                    // Final round has no MixColumns.
                    ct_d        = w_shifted ^ w_round_key;
                    ct_valid_d  = 1'b1;
                    round_d     = 4'd0;
                    fsm_d       = OUT_S;
                end else begin
                    aes_state_d = w_mixed ^ w_round_key;
                    round_d     = round_q + 4'd1;
                end
            end

            OUT_S: begin
                // Key validity is irrelevant here: the result is complete.
                if (ciphertext_ready_i) begin
                    ct_valid_d = 1'b0;
                    fsm_d      = IDLE_S;
                end
            end

            default: begin
                fsm_d       = IDLE_S;
                round_d     = 4'd0;
                aes_state_d = '0;
                ct_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE_S;
            round_q     <= 4'd0;
            aes_state_q <= '0;
            ct_q        <= '0;
            ct_valid_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            aes_state_q <= aes_state_d;
            ct_q        <= ct_d;
            ct_valid_q  <= ct_valid_d;
            abort_q     <= abort_d;
        end
    end

    assign plaintext_ready_o  = w_ready;
    assign ciphertext_o       = ct_q;
    assign ciphertext_valid_o = ct_valid_q;
    assign key_abort_o        = abort_q;

`ifdef AES_BLOCK_COUNT_EN
    // Counts completed output handshakes; wraps naturally at 2^32.
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if ((fsm_q == OUT_S) && ciphertext_ready_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign block_count_o = count_q;
`endif

endmodule

`default_nettype wire
